// File: rtl/dma_pkg.sv
// Shared types for the DMA write channel: FSM states and counter type.
// count_t is the lines-counter type for the default cache-line width.
package dma_pkg;

    localparam int CL_AW = 42;

    typedef logic [CL_AW:0] count_t;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/fifo.sv
// Show-ahead line buffer: rd_data is the oldest entry while !empty.
// Ports: clk, rst (async high), clr (sync flush), wr_en/wr_data, rd_en/rd_data, full, empty.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage has no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            if (do_wr && !do_rd) begin
                count <= count + 1'b1;
            end else if (do_rd && !do_wr) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_wr_channel.sv
// DMA write channel: buffers producer lines and issues them as cache-line writes.
// Ports: go/wr_addr/wr_size start a run; wr_en/wr_data/full from producer;
// mem_wr_* to memory, mem_almost_full throttles, mem_wr_ack completes; wr_done.
module dma_wr_channel
    import dma_pkg::*;
#(
    parameter int ADDR_WIDTH    = 64,
    parameter int CL_ADDR_WIDTH = 42,
    parameter int DATA_WIDTH    = 512,
    parameter int FIFO_DEPTH    = 512
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     go,
    input  logic [ADDR_WIDTH-1:0]    wr_addr,
    input  logic [CL_ADDR_WIDTH:0]   wr_size,
    input  logic                     wr_en,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    output logic                     full,
    output logic                     wr_done,
    output logic                     mem_wr_valid,
    output logic [CL_ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0]    mem_wr_data,
    input  logic                     mem_almost_full,
    input  logic                     mem_wr_ack
);

    localparam int CW = CL_ADDR_WIDTH + 1;

    state_t                   state;
    logic [CL_ADDR_WIDTH-1:0] base;
    logic [CW-1:0]            size;
    logic [CW-1:0]            acc_cnt;
    logic [CW-1:0]            iss_cnt;
    logic [CW-1:0]            ack_cnt;
    logic                     buf_full;
    logic                     buf_empty;
    logic [DATA_WIDTH-1:0]    buf_data;
    logic                     start;
    logic                     accept;
    logic                     issue;
    logic                     ack_ok;

    assign start  = go && ((state == IDLE) || (state == DONE));
    assign full   = (state != ACTIVE) || buf_full || (acc_cnt == size);
    assign accept = wr_en && !full;
    assign issue  = !buf_empty && !mem_almost_full &&
                    ((state == ACTIVE) || (state == DRAIN));
    // An ack with nothing outstanding is stale and must not count.
    assign ack_ok = mem_wr_ack && (ack_cnt != iss_cnt);

    fifo #(
        .WIDTH(DATA_WIDTH),
        .DEPTH(FIFO_DEPTH)
    ) u_buf (
        .clk    (clk),
        .rst    (rst),
        .clr    (start),
        .wr_en  (accept),
        .wr_data(wr_data),
        .rd_en  (issue),
        .rd_data(buf_data),
        .full   (buf_full),
        .empty  (buf_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            base         <= '0;
            size         <= '0;
            acc_cnt      <= '0;
            iss_cnt      <= '0;
            ack_cnt      <= '0;
            wr_done      <= 1'b0;
            mem_wr_valid <= 1'b0;
            mem_wr_addr  <= '0;
            mem_wr_data  <= '0;
        end else begin
            mem_wr_valid <= issue;
            if (issue) begin
                mem_wr_addr <= base + iss_cnt[CL_ADDR_WIDTH-1:0];
                mem_wr_data <= buf_data;
            end
            if (start) begin
                base    <= CL_ADDR_WIDTH'(wr_addr >> 6);
                size    <= wr_size;
                acc_cnt <= '0;
                iss_cnt <= '0;
                ack_cnt <= '0;
                wr_done <= 1'b0;
                state   <= ACTIVE;
            end else begin
                if (accept) acc_cnt <= acc_cnt + 1'b1;
                if (issue)  iss_cnt <= iss_cnt + 1'b1;
                if (ack_ok) ack_cnt <= ack_cnt + 1'b1;
                unique case (state)
                    ACTIVE: begin
                        // Only a zero-length run can be fully acked here.
                        if (acc_cnt == size) begin
                            if (ack_cnt == size) begin
                                state   <= DONE;
                                wr_done <= 1'b1;
                            end else begin
                                state <= DRAIN;
                            end
                        end
                    end
                    DRAIN: begin
                        if (ack_cnt == size) begin
                            state   <= DONE;
                            wr_done <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
